// File: rtl/keypad_lock_ctrl.sv
// Keypad lock controller: sets a passcode by double entry, unlocks on a match,
// with press-edge detection, idle timeout, timed error and attempt-limited lockout.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_SET1    | unlocked, collecting first entry of a new passcode
// ST_SET2    | unlocked, collecting confirmation entry
// ST_LOCKED  | locked, collecting an unlock attempt
// ST_ERROR   | error shown, keys ignored, then back to r_ret_state
// ST_LOCKOUT | too many failed attempts, keys ignored for a fixed time
module keypad_lock_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int PASSCODE_LENGTH = 4,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int ERROR_CYCLES    = 50,
    parameter int LOCKOUT_CYCLES  = 1000,
    parameter int IDLE_TIMEOUT    = 500
) (
    input  logic                                    i_clock,
    input  logic                                    i_reset,
    input  logic [NUM_KEYS-1:0]                     i_key,
    output logic                                    o_locked,
    output logic                                    o_error,
    output logic                                    o_lockout,
    output logic                                    o_digit_accepted,
    output logic [$clog2(PASSCODE_LENGTH+1)-1:0]    o_entry_count,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]       o_attempts_left
);

    localparam int EW     = NUM_KEYS * PASSCODE_LENGTH;
    localparam int CNT_W  = $clog2(PASSCODE_LENGTH + 1);
    localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int T_MAX0 = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX  = (T_MAX0 > IDLE_TIMEOUT) ? T_MAX0 : IDLE_TIMEOUT;
    localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0] ERR_LOAD  = TMR_W'(ERROR_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] IDLE_LOAD = TMR_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PASSCODE_LENGTH - 1);
    localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        ST_SET1    = 3'd0,
        ST_SET2    = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    state_t              r_ret_state, w_ret_nxt;
    logic [NUM_KEYS-1:0] r_key_prev;
    logic [EW-1:0]       r_entry, w_entry_nxt;
    logic                r_entry_valid, w_valid_nxt;
    logic [EW-1:0]       r_cand, w_cand_nxt;
    logic                r_cand_valid, w_cand_valid_nxt;
    logic [EW-1:0]       r_pass, w_pass_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [TMR_W-1:0]    r_timer, w_timer_nxt;
    logic [ATT_W-1:0]    r_attempts, w_att_nxt;
    logic                r_locked, w_locked_nxt;
    logic                r_error, w_error_nxt;
    logic                r_lockout, w_lockout_nxt;
    logic                r_digit_acc, w_da_nxt;

    logic                w_press;
    logic [EW-1:0]       w_entry_shift;
    logic                w_valid_final;
    logic [ATT_W-1:0]    w_att_dec;

    assign w_press       = (i_key != '0) && (r_key_prev == '0);
    // New digit enters at the bottom, so the first digit ends up in the top slot.
    assign w_entry_shift = (r_entry << NUM_KEYS) | EW'(i_key);
    assign w_valid_final = r_entry_valid && $onehot(i_key);
    assign w_att_dec     = r_attempts - ATT_W'(1);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_SET1;
            r_ret_state   <= ST_SET1;
            r_key_prev    <= '0;
            r_entry       <= '0;
            r_entry_valid <= 1'b1;
            r_cand        <= '0;
            r_cand_valid  <= 1'b0;
            r_pass        <= '0;
            r_count       <= '0;
            r_timer       <= IDLE_LOAD;
            r_attempts    <= ATT_MAX;
            r_locked      <= 1'b0;
            r_error       <= 1'b0;
            r_lockout     <= 1'b0;
            r_digit_acc   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ret_state   <= w_ret_nxt;
            r_key_prev    <= i_key;
            r_entry       <= w_entry_nxt;
            r_entry_valid <= w_valid_nxt;
            r_cand        <= w_cand_nxt;
            r_cand_valid  <= w_cand_valid_nxt;
            r_pass        <= w_pass_nxt;
            r_count       <= w_count_nxt;
            r_timer       <= w_timer_nxt;
            r_attempts    <= w_att_nxt;
            r_locked      <= w_locked_nxt;
            r_error       <= w_error_nxt;
            r_lockout     <= w_lockout_nxt;
            r_digit_acc   <= w_da_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ret_nxt        = r_ret_state;
        w_entry_nxt      = r_entry;
        w_valid_nxt      = r_entry_valid;
        w_cand_nxt       = r_cand;
        w_cand_valid_nxt = r_cand_valid;
        w_pass_nxt       = r_pass;
        w_count_nxt      = r_count;
        w_timer_nxt      = (r_timer != '0) ? (r_timer - TMR_W'(1)) : r_timer;
        w_att_nxt        = r_attempts;
        w_locked_nxt     = r_locked;
        w_error_nxt      = r_error;
        w_lockout_nxt    = r_lockout;
        w_da_nxt         = 1'b0;

        case (r_state)
            ST_SET1, ST_SET2, ST_LOCKED: begin
                if (w_press) begin
                    w_da_nxt    = 1'b1;
                    w_timer_nxt = IDLE_LOAD;
                    if (r_count != LAST_IDX) begin
                        w_entry_nxt = w_entry_shift;
                        w_valid_nxt = w_valid_final;
                        w_count_nxt = r_count + CNT_W'(1);
                    end else begin
                        w_entry_nxt = '0;
                        w_valid_nxt = 1'b1;
                        w_count_nxt = '0;
                        case (r_state)
                            ST_SET1: begin
                                w_cand_nxt       = w_entry_shift;
                                w_cand_valid_nxt = w_valid_final;
                                w_state_nxt      = ST_SET2;
                            end
                            ST_SET2: begin
                                if ((w_entry_shift == r_cand) && w_valid_final && r_cand_valid) begin
                                    w_pass_nxt   = r_cand;
                                    w_locked_nxt = 1'b1;
                                    w_att_nxt    = ATT_MAX;
                                    w_state_nxt  = ST_LOCKED;
                                end else begin
                                    w_error_nxt  = 1'b1;
                                    w_ret_nxt    = ST_SET1;
                                    w_timer_nxt  = ERR_LOAD;
                                    w_state_nxt  = ST_ERROR;
                                end
                                w_cand_nxt       = '0;
                                w_cand_valid_nxt = 1'b0;
                            end
                            default: begin
                                if ((w_entry_shift == r_pass) && w_valid_final) begin
                                    w_locked_nxt = 1'b0;
                                    w_att_nxt    = ATT_MAX;
                                    w_state_nxt  = ST_SET1;
                                end else begin
                                    w_att_nxt = w_att_dec;
                                    if (w_att_dec == '0) begin
                                        w_lockout_nxt = 1'b1;
                                        w_error_nxt   = 1'b0;
                                        w_timer_nxt   = LOCK_LOAD;
                                        w_state_nxt   = ST_LOCKOUT;
                                    end else begin
                                        w_error_nxt = 1'b1;
                                        w_ret_nxt   = ST_LOCKED;
                                        w_timer_nxt = ERR_LOAD;
                                        w_state_nxt = ST_ERROR;
                                    end
                                end
                            end
                        endcase
                    end
                end else if ((r_count != '0) && (r_timer == '0)) begin
                    // Abandoned partial entry: discard silently, no attempt consumed.
                    w_entry_nxt = '0;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = '0;
                    if (r_state == ST_SET2) begin
                        w_cand_nxt       = '0;
                        w_cand_valid_nxt = 1'b0;
                        w_timer_nxt      = IDLE_LOAD;
                        w_state_nxt      = ST_SET1;
                    end
                end
            end
            ST_ERROR: begin
                if (r_timer == '0) begin
                    w_error_nxt = 1'b0;
                    w_entry_nxt = '0;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = '0;
                    w_timer_nxt = IDLE_LOAD;
                    w_state_nxt = r_ret_state;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_lockout_nxt = 1'b0;
                    w_att_nxt     = ATT_MAX;
                    w_timer_nxt   = IDLE_LOAD;
                    w_state_nxt   = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_SET1;
            end
        endcase
    end

    assign o_locked         = r_locked;
    assign o_error          = r_error;
    assign o_lockout        = r_lockout;
    assign o_digit_accepted = r_digit_acc;
    assign o_entry_count    = r_count;
    assign o_attempts_left  = r_attempts;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed self-checking bench for keypad_lock_ctrl: a per-cycle vector table
// for set/unlock/error flow, then hand sequences for lockout, hold, timeout, reset.
module tb_keypad_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic       locked, error, lockout, da;
    logic [1:0] cnt, att;

    keypad_lock_ctrl #(
        .NUM_KEYS(4), .PASSCODE_LENGTH(3), .MAX_ATTEMPTS(3),
        .ERROR_CYCLES(4), .LOCKOUT_CYCLES(20), .IDLE_TIMEOUT(10)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_key(key),
        .o_locked(locked), .o_error(error), .o_lockout(lockout),
        .o_digit_accepted(da), .o_entry_count(cnt), .o_attempts_left(att)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int da_count = 0;
    int lo_count = 0;

    always @(posedge clk) begin
        #2;
        if (da) da_count++;
        if (lockout) lo_count++;
    end

    typedef struct {
        logic [3:0] k;
        logic       e_locked, e_error, e_lockout, e_da;
        logic [1:0] e_cnt, e_att;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One release cycle, then the key; returns just after the edge that samples it.
    task automatic press(input logic [3:0] k);
        key = 4'b0000;
        tick(1);
        key = k;
        tick(1);
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press(a);
        press(b);
        press(c);
    endtask

    task automatic wait_err(input string name);
        int n;
        n = 0;
        while (error && n < 40) begin
            n++;
            tick(1);
        end
        chk({name, "_error_cycles"}, n, 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lo_base, n;
        //        key      lck err lko da  cnt   att
        tbl[0]  = '{4'b1000, 0, 0, 0, 1, 2'd1, 2'd3};
        tbl[1]  = '{4'b0000, 0, 0, 0, 0, 2'd1, 2'd3};
        tbl[2]  = '{4'b0001, 0, 0, 0, 1, 2'd2, 2'd3};
        tbl[3]  = '{4'b0000, 0, 0, 0, 0, 2'd2, 2'd3};
        tbl[4]  = '{4'b0100, 0, 0, 0, 1, 2'd0, 2'd3};
        tbl[5]  = '{4'b0000, 0, 0, 0, 0, 2'd0, 2'd3};
        tbl[6]  = '{4'b1000, 0, 0, 0, 1, 2'd1, 2'd3};
        tbl[7]  = '{4'b1000, 0, 0, 0, 0, 2'd1, 2'd3};
        tbl[8]  = '{4'b0000, 0, 0, 0, 0, 2'd1, 2'd3};
        tbl[9]  = '{4'b0001, 0, 0, 0, 1, 2'd2, 2'd3};
        tbl[10] = '{4'b0000, 0, 0, 0, 0, 2'd2, 2'd3};
        tbl[11] = '{4'b0100, 1, 0, 0, 1, 2'd0, 2'd3};
        tbl[12] = '{4'b0000, 1, 0, 0, 0, 2'd0, 2'd3};
        tbl[13] = '{4'b1000, 1, 0, 0, 1, 2'd1, 2'd3};
        tbl[14] = '{4'b0000, 1, 0, 0, 0, 2'd1, 2'd3};
        tbl[15] = '{4'b0100, 1, 0, 0, 1, 2'd2, 2'd3};
        tbl[16] = '{4'b0000, 1, 0, 0, 0, 2'd2, 2'd3};
        tbl[17] = '{4'b0010, 1, 1, 0, 1, 2'd0, 2'd2};
        tbl[18] = '{4'b0000, 1, 1, 0, 0, 2'd0, 2'd2};
        tbl[19] = '{4'b1000, 1, 1, 0, 0, 2'd0, 2'd2};
        tbl[20] = '{4'b1000, 1, 1, 0, 0, 2'd0, 2'd2};
        tbl[21] = '{4'b1000, 1, 0, 0, 0, 2'd0, 2'd2};
        tbl[22] = '{4'b1000, 1, 0, 0, 0, 2'd0, 2'd2};
        tbl[23] = '{4'b0000, 1, 0, 0, 0, 2'd0, 2'd2};
        tbl[24] = '{4'b1000, 1, 0, 0, 1, 2'd1, 2'd2};
        tbl[25] = '{4'b0000, 1, 0, 0, 0, 2'd1, 2'd2};
        tbl[26] = '{4'b0001, 1, 0, 0, 1, 2'd2, 2'd2};
        tbl[27] = '{4'b0000, 1, 0, 0, 0, 2'd2, 2'd2};
        tbl[28] = '{4'b0100, 0, 0, 0, 1, 2'd0, 2'd3};
        tbl[29] = '{4'b0000, 0, 0, 0, 0, 2'd0, 2'd3};

        key   = 4'b0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_da", da, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_att", att, 3);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            key = tbl[i].k;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_locked", i), locked, tbl[i].e_locked);
            chk($sformatf("vec%0d_error", i), error, tbl[i].e_error);
            chk($sformatf("vec%0d_lockout", i), lockout, tbl[i].e_lockout);
            chk($sformatf("vec%0d_da", i), da, tbl[i].e_da);
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].e_cnt);
            chk($sformatf("vec%0d_att", i), att, tbl[i].e_att);
        end

        // Set mismatch, then a fresh double entry proves we are back at the first entry.
        base = da_count;
        enter(4'b1000, 4'b0001, 4'b0100);
        enter(4'b1000, 4'b0001, 4'b1000);
        chk("mis_error", error, 1);
        chk("mis_locked", locked, 0);
        chk("mis_cnt", cnt, 0);
        chk("mis_da_pulses", da_count - base, 6);
        wait_err("mis");
        enter(4'b1000, 4'b0001, 4'b0100);
        chk("reset_first_locked", locked, 0);
        enter(4'b1000, 4'b0001, 4'b0100);
        chk("reset_second_locked", locked, 1);
        chk("reset_second_att", att, 3);

        // Three wrong entries lead to lockout without error.
        enter(4'b1000, 4'b0100, 4'b0010);
        chk("lo_w1_att", att, 2);
        wait_err("lo_w1");
        enter(4'b1000, 4'b0100, 4'b0010);
        chk("lo_w2_att", att, 1);
        wait_err("lo_w2");
        lo_base = lo_count;
        enter(4'b1000, 4'b0100, 4'b0010);
        chk("lo_lockout", lockout, 1);
        chk("lo_error", error, 0);
        chk("lo_att", att, 0);
        chk("lo_locked", locked, 1);
        base = da_count;
        press(4'b1000);
        press(4'b0010);
        chk("lo_press_cnt", cnt, 0);
        chk("lo_press_da", da_count - base, 0);
        n = 0;
        while (lockout && n < 60) begin
            n++;
            tick(1);
        end
        chk("lo_cycles", lo_count - lo_base, 20);
        chk("lo_end_att", att, 3);
        chk("lo_end_locked", locked, 1);
        enter(4'b1000, 4'b0001, 4'b0100);
        chk("lo_unlock_locked", locked, 0);
        chk("lo_unlock_att", att, 3);

        // Held key counts once; a two-bit digit makes the entry fail.
        enter(4'b1000, 4'b0001, 4'b0100);
        enter(4'b1000, 4'b0001, 4'b0100);
        chk("hold_relock", locked, 1);
        base = da_count;
        press(4'b1000);
        tick(4);
        chk("hold_cnt", cnt, 1);
        chk("hold_da", da_count - base, 1);
        press(4'b1100);
        chk("inv_cnt", cnt, 2);
        press(4'b0100);
        chk("inv_error", error, 1);
        chk("inv_att", att, 2);
        chk("inv_locked", locked, 1);
        wait_err("inv");

        // Idle timeout: entry survives 9 quiet cycles, is discarded on the 10th.
        press(4'b1000);
        press(4'b0001);
        tick(9);
        chk("idle_before_cnt", cnt, 2);
        tick(1);
        chk("idle_after_cnt", cnt, 0);
        chk("idle_error", error, 0);
        chk("idle_att", att, 2);

        // Reach lockout again and reset asynchronously in the middle of it.
        enter(4'b1000, 4'b0100, 4'b0010);
        chk("rst2_w1_att", att, 1);
        wait_err("rst2_w1");
        enter(4'b1000, 4'b0100, 4'b0010);
        chk("rst2_lockout_pre", lockout, 1);
        tick(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_lockout", lockout, 0);
        chk("async_att", att, 3);
        chk("async_cnt", cnt, 0);
        chk("async_error", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        key = 4'b0000;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
